wb_load_store_unit: RTL
=======================

# wb_load_store_unit

Parametrised load/store unit sitting between the core's control unit and the Wishbone data bus, successor to `memory_access`. It executes RV32 LB/LH/LW/LBU/LHU/SB/SH/SW on a 32- or 64-bit Wishbone bus and drives byte selects. It splits boundary-crossing (misaligned) accesses into a two-beat burst and retries on RTY up to a bounded count. Errors are reported to the control unit as a single pulse.

## Interface
- BUS_BYTES, 4: data bus width in bytes (4 or 8); DAT_I/DAT_O are 8*BUS_BYTES wide.
- ALLOW_MISALIGNED, 1: 1 = split boundary-crossing accesses into two beats; 0 = report err without a bus cycle.
- MAX_RETRY, 3: number of RTY responses tolerated per beat before err.
- Reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- memory_operation  in  memory_operation_t  LOAD_DATA / STORE_DATA (global_pkg).
- cyc  in  1  level request from the control unit.
- funct3  in  3  RV32 load/store funct3.
- address  in  32  byte address.
- store_data  in  32  store operand, LSB-aligned.
- ack  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse.
- data_valid  out  1  load_data valid.
- load_data  out  32  extended load result.
- CYC, STB, WE  out  1  Wishbone master controls.
- ADR  out  32  BUS_BYTES-aligned address.
- SEL  out  BUS_BYTES  byte lane enables.
- DAT_O  out  8*BUS_BYTES  write data.
- CTI_O  out  3  000 classic, 010 incrementing burst, 111 end of burst.
- ACK, ERR, RTY  in  1  Wishbone slave responses.
- DAT_I  in  8*BUS_BYTES  read data.

## Operation
- States: IDLE, BEAT0, BEAT1, DONE.
- IDLE, cyc=1: latch address, funct3, store_data and op.
  - size = 1/2/4 bytes for funct3[1:0] = 0/1/2.
  - Legal funct3: loads 000, 001, 010, 100, 101; stores 000, 001, 010.
  - Illegal funct3 goes to DONE with err, no bus cycle.
- off = address mod BUS_BYTES. The access is split when off+size > BUS_BYTES.
  - Split with ALLOW_MISALIGNED=0: go to DONE with err, no bus cycle.
- BEAT0: ADR = address with the low bits cleared.
  - SEL covers bytes off up to min(off+size, BUS_BYTES)-1.
  - DAT_O = store_data shifted left by 8*off.
  - CTI_O = 010 if split, else 000.
- BEAT1 (split only): ADR = BEAT0 ADR + BUS_BYTES.
  - SEL covers the remaining low bytes; DAT_O carries the remaining store bytes from lane 0; CTI_O = 111.
  - CYC stays high between beats.
- Responses, sampled each posedge while STB is high:
  - ACK: capture the SEL'd DAT_I bytes and advance the beat.
  - RTY: reissue the same beat and increment the retry counter (reset per beat). The RTY that exceeds MAX_RETRY is treated as ERR.
  - ERR: drop CYC/STB, go to DONE with err.
  - Priority: ERR > RTY > ACK.
- Loads: assembled bytes are sign-extended (LB/LH) or zero-extended (LBU/LHU). load_data and data_valid update only on successful completion.
- DONE: wait until cyc is sampled low, then return to IDLE. data_valid stays high until the next request is accepted.
- WE = (op == STORE_DATA) for the whole transaction.

## Timing
- Reset values: CYC=STB=WE=0, ADR=0, SEL=0, DAT_O=0, CTI_O=000, ack=err=data_valid=0, load_data=0, state IDLE, retry counter 0.
- All outputs are registered.
- Request: cyc is sampled at edge n; CYC/STB are high after edge n+1.
- Completion:
  - Final ACK is sampled at edge k. After edge k, CYC/STB are low and ack is high for exactly one cycle (data_valid also high for loads).
  - Minimum single-beat latency with a zero-wait slave: 2 cycles. Each extra beat or RTY adds 1 cycle.
- Error detection:
  - Decode errors (illegal funct3, split with ALLOW_MISALIGNED=0): err is high one cycle after cyc is sampled; CYC never asserts.
  - Bus errors: err follows the sampled ERR one edge later.
- ack and err are never high together.
- rst during a transaction: at the next edge CYC/STB drop and state goes to IDLE, with no ack/err. load_data resets to 0.
- cyc high in any state other than IDLE is ignored. Back-to-back requests need cyc low for at least one sampled edge.

## Test plan
Memory is word0 = 0x44332211, word1 = 0xF8F7F6F5, BUS_BYTES=4.
- LB addr 5 -> load_data 0xFFFFFFF6; LBU addr 5 -> 0x000000F6. Each is a single beat with SEL=0010, CTI_O=000.
- LW addr 2 -> two beats:
  - Beat 0: ADR 0, SEL 1100, CTI_O 010.
  - Beat 1: ADR 4, SEL 0011, CTI_O 111.
  - Result: load_data 0xF6F54433, one ack pulse.
- SH addr 3 with store_data 0x0000ABCD:
  - Beat 0: SEL 1000, DAT_O[31:24]=0xCD.
  - Beat 1: SEL 0001, DAT_O[7:0]=0xAB.
  - Result: word0 = 0xCD332211, word1 = 0xF8F7F6AB.
- Slave retries, MAX_RETRY=3:
  - RTY twice then ACK on LW addr 0 -> 3 STB attempts, ack, load_data 0x44332211.
  - RTY 4 times -> err pulse, CYC low, data_valid 0.
- ERR on beat 1 of a split LH at addr 3 -> err one cycle later, no ack, load_data unchanged.
- Decode errors:
  - funct3 = 011 -> err after 1 cycle, CYC never asserted.
  - ALLOW_MISALIGNED=0 with LW addr 2 -> same response.
- rst asserted while BEAT1 is pending -> next cycle CYC=0, ack=0, err=0, state IDLE.

Source files
------------

// File: rtl/global_pkg.sv
// rtl/global_pkg.sv - shared core types used by the load/store path
package global_pkg;

   typedef enum logic {
      LOAD_DATA  = 1'b0,
      STORE_DATA = 1'b1
   } memory_operation_t;

endpackage

// File: rtl/wb_load_store_unit.sv
// rtl/wb_load_store_unit.sv - RV32 load/store unit with Wishbone master, split beats and RTY retry
module wb_load_store_unit
   import global_pkg::*;
#(
   parameter int BUS_BYTES        = 4,
   parameter bit ALLOW_MISALIGNED = 1'b1,
   parameter int MAX_RETRY        = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  memory_operation_t        memory_operation,
   input  logic                     cyc,
   input  logic [2:0]               funct3,
   input  logic [31:0]              address,
   input  logic [31:0]              store_data,
   output logic                     ack,
   output logic                     err,
   output logic                     data_valid,
   output logic [31:0]              load_data,
   output logic                     CYC,
   output logic                     STB,
   output logic                     WE,
   output logic [31:0]              ADR,
   output logic [BUS_BYTES-1:0]     SEL,
   output logic [8*BUS_BYTES-1:0]   DAT_O,
   output logic [2:0]               CTI_O,
   input  logic                     ACK,
   input  logic                     ERR,
   input  logic                     RTY,
   input  logic [8*BUS_BYTES-1:0]   DAT_I
);

   localparam int DW   = 8 * BUS_BYTES;
   localparam int OFFW = $clog2(BUS_BYTES);
   localparam int RW   = $clog2(MAX_RETRY + 2);

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

   state_t          state, state_nxt;
   logic [31:0]     req_addr;
   logic [2:0]      req_funct3;
   logic [31:0]     req_data;
   logic            req_store;
   logic [RW-1:0]   rty_cnt;
   logic [31:0]     rbuf;

   int              off_i, size_i, n0_i;
   logic            legal, split, dec_err;
   logic [31:0]     base_adr;
   logic [BUS_BYTES-1:0] sel0, sel1;
   logic [DW-1:0]   sd_wide, dat0, dat1;
   logic [31:0]     asm_w, ext_w;
   logic            rty_over, bus_err, bus_rty, bus_ack;

   // Decode the latched request into beat geometry, lane enables and write data
   always_comb begin
      off_i = int'(req_addr[OFFW-1:0]);
      case (req_funct3[1:0])
         2'b00:   size_i = 1;
         2'b01:   size_i = 2;
         default: size_i = 4;
      endcase
      split = (off_i + size_i > BUS_BYTES);
      n0_i  = split ? (BUS_BYTES - off_i) : size_i;
      if (req_store)
         legal = (req_funct3 inside {3'b000, 3'b001, 3'b010});
      else
         legal = (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      dec_err  = !legal || (split && (ALLOW_MISALIGNED == 1'b0));
      base_adr = {req_addr[31:OFFW], {OFFW{1'b0}}};
      sd_wide  = DW'(req_data);
      dat0     = sd_wide << (8 * off_i);
      dat1     = sd_wide >> (8 * n0_i);
      for (int j = 0; j < BUS_BYTES; j++) begin
         sel0[j] = (j >= off_i) && (j < off_i + size_i);
         sel1[j] = (j < size_i - n0_i);
      end
   end

   // Merge the current beat's selected lanes into the result and extend it
   always_comb begin
      asm_w = rbuf;
      for (int i = 0; i < 4; i++) begin
         if (state == BEAT1) begin
            if (i >= n0_i && i < size_i)
               asm_w[8*i +: 8] = DAT_I[8*(i - n0_i) +: 8];
         end else if (i < size_i && off_i + i < BUS_BYTES) begin
            asm_w[8*i +: 8] = DAT_I[8*(off_i + i) +: 8];
         end
      end
      case (req_funct3)
         3'b000:  ext_w = {{24{asm_w[7]}}, asm_w[7:0]};
         3'b001:  ext_w = {{16{asm_w[15]}}, asm_w[15:0]};
         3'b100:  ext_w = {24'b0, asm_w[7:0]};
         3'b101:  ext_w = {16'b0, asm_w[15:0]};
         default: ext_w = asm_w;
      endcase
   end

   // Classify the slave response with ERR > RTY > ACK; an RTY past the budget becomes an error
   always_comb begin
      rty_over = (rty_cnt == RW'(MAX_RETRY));
      bus_err  = STB && (ERR || (RTY && rty_over));
      bus_rty  = STB && !ERR && RTY && !rty_over;
      bus_ack  = STB && !ERR && !RTY && ACK;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; a beat state with STB low is the launch cycle after a request is latched
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (cyc) state_nxt = BEAT0;
         BEAT0, BEAT1: begin
            if (!STB) begin
               if (dec_err) state_nxt = DONE;
            end else if (bus_err) begin
               state_nxt = DONE;
            end else if (bus_ack) begin
               state_nxt = (state == BEAT0 && split) ? BEAT1 : DONE;
            end
         end
         DONE: if (!cyc) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Registered bus controls, request capture, retry counting and completion pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         CYC <= 1'b0; STB <= 1'b0; WE <= 1'b0; ADR <= '0; SEL <= '0; DAT_O <= '0; CTI_O <= 3'b000;
         ack <= 1'b0; err <= 1'b0; data_valid <= 1'b0; load_data <= '0;
         req_addr <= '0; req_funct3 <= '0; req_data <= '0; req_store <= 1'b0;
         rty_cnt <= '0; rbuf <= '0;
      end else begin
         ack <= 1'b0;
         err <= 1'b0;
         case (state)
            IDLE: begin
               if (cyc) begin
                  req_addr   <= address;
                  req_funct3 <= funct3;
                  req_data   <= store_data;
                  req_store  <= (memory_operation == STORE_DATA);
                  data_valid <= 1'b0;
                  rty_cnt    <= '0;
                  rbuf       <= '0;
               end
            end
            BEAT0, BEAT1: begin
               if (!STB) begin
                  if (dec_err) begin
                     err <= 1'b1;
                  end else begin
                     CYC <= 1'b1; STB <= 1'b1; WE <= req_store;
                     ADR <= base_adr; SEL <= sel0; DAT_O <= dat0;
                     CTI_O <= split ? 3'b010 : 3'b000;
                  end
               end else if (bus_err) begin
                  CYC <= 1'b0; STB <= 1'b0; WE <= 1'b0; ADR <= '0; SEL <= '0; DAT_O <= '0; CTI_O <= 3'b000;
                  err <= 1'b1;
               end else if (bus_rty) begin
                  rty_cnt <= rty_cnt + RW'(1);
               end else if (bus_ack) begin
                  rbuf <= asm_w;
                  if (state == BEAT0 && split) begin
                     ADR <= base_adr + 32'(BUS_BYTES); SEL <= sel1; DAT_O <= dat1;
                     CTI_O <= 3'b111; rty_cnt <= '0;
                  end else begin
                     CYC <= 1'b0; STB <= 1'b0; WE <= 1'b0; ADR <= '0; SEL <= '0; DAT_O <= '0; CTI_O <= 3'b000;
                     ack <= 1'b1;
                     if (!req_store) begin
                        data_valid <= 1'b1;
                        load_data  <= ext_w;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
